bus_dma_master: RTL and testbench



---
 rtl/bus_pkg.sv | 32 +++
 rtl/dma_addr_cnt.sv | 43 ++++
 rtl/bus_dma_master.sv | 154 +++++++++++++++
 tb/tb_bus_dma_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths, DMA state encoding and the
// address windows decoded on the shared single-master bus.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 64;
    localparam int BUS_LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        WR      = 3'd4,
        DONE    = 3'd5
    } dma_state_e;

    localparam logic [BUS_ADDR_W-1:0] MEM_BASE    = 16'h0000;
    localparam logic [BUS_ADDR_W-1:0] MEM_LAST    = 16'h07FF;
    localparam logic [BUS_ADDR_W-1:0] PERIPH_BASE = 16'h7000;
    localparam logic [BUS_ADDR_W-1:0] PERIPH_LAST = 16'h71FF;

    // The memory window starts at address zero, so only the upper bound matters.
    function automatic logic in_mem_window(input logic [BUS_ADDR_W-1:0] addr);
        return addr <= MEM_LAST;
    endfunction

    function automatic logic in_periph_window(input logic [BUS_ADDR_W-1:0] addr);
        return (addr >= PERIPH_BASE) && (addr <= PERIPH_LAST);
    endfunction

endpackage

// File: rtl/dma_addr_cnt.sv
// Source/destination address incrementers and word down-counter for the DMA
// master. Addresses wrap modulo 2^ADDR_W.
module dma_addr_cnt #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] src_q,
    output logic [ADDR_W-1:0] dst_q,
    output logic              cnt_zero,
    output logic              cnt_last
);

    logic [LEN_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments and an async
    // active-low reset so every register settles to a known value together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            src_q <= src_in;
            dst_q <= dst_in;
            cnt_q <= len_in;
        end else if (step) begin
            src_q <= src_q + ADDR_W'(1);
            dst_q <= dst_q + ADDR_W'(1);
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

    assign cnt_zero = (cnt_q == '0);
    assign cnt_last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/bus_dma_master.sv
// Bus DMA master: copies consecutive words from a source range to a destination
// range. Define BUS_DMA_FILL_EN to add a fill mode that writes a constant word.
module bus_dma_master
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef BUS_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    output logic              busy,
    output logic              done
);

    dma_state_e        state_q, state_d;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic              cnt_zero, cnt_last;
    logic              load, step;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_word;

    assign load = (state_q == IDLE) && start;
    assign step = (state_q == WR) && m_grant;

    dma_addr_cnt #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .step     (step),
        .src_in   (src_addr),
        .dst_in   (dst_addr),
        .len_in   (length),
        .src_q    (src_q),
        .dst_q    (dst_q),
        .cnt_zero (cnt_zero),
        .cnt_last (cnt_last)
    );

`ifdef BUS_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q      <= 1'b0;
            fill_data_q <= '0;
        end else if (load) begin
            fill_q      <= fill;
            fill_data_q <= fill_data;
        end
    end

    assign fill_mode = fill_q;
    assign fill_word = fill_data_q;
`else
    assign fill_mode = 1'b0;
    assign fill_word = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            // Read data lags the address by one cycle, so it is valid in RD_WAIT.
            if ((state_q == RD_WAIT) && m_grant) begin
                buf_q <= m_din;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_dout  = '0;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (length == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                m_req = 1'b1;
                if (m_grant) begin
                    state_d = fill_mode ? WR : RD;
                end
            end
            RD: begin
                m_req  = 1'b1;
                m_addr = src_q;
                if (m_grant) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                m_req  = 1'b1;
                m_addr = src_q;
                if (m_grant) begin
                    state_d = WR;
                end
            end
            WR: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = dst_q;
                m_dout = fill_mode ? fill_word : buf_q;
                if (m_grant) begin
                    // cnt_zero cannot occur here in normal flow; treat it as the end too.
                    if (cnt_last || cnt_zero) begin
                        state_d = DONE;
                    end else begin
                        state_d = fill_mode ? WR : RD;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed testbench for bus_dma_master with a one-cycle-latency bus memory
// model and a registered arbiter; fill mode is exercised when BUS_DMA_FILL_EN is set.
module tb_bus_dma_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  length = '0;
    logic        m_grant;
    logic [63:0] m_din;
    logic        m_req, m_wr, busy, done;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
`ifdef BUS_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [63:0] fill_data = '0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Bus model: registered grant with a forcing mask, and a memory whose read
    // data appears one cycle after the address. Preload goes through a backdoor port.
    logic        grant_q;
    logic        grant_block = 1'b0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [63:0] pl_data = '0;
    logic [63:0] mem [0:65535];
    logic [15:0] wr_log [$];

    assign m_grant = grant_q & ~grant_block;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) grant_q <= 1'b0;
        else          grant_q <= m_req;
    end

    always @(posedge clk) begin
        m_din <= mem[m_addr];
        if (pl_en) mem[pl_addr] <= pl_data;
        if (m_req && m_grant && m_wr) begin
            mem[m_addr] <= m_dout;
            wr_log.push_back(m_addr);
        end
    end

    bus_dma_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
`ifdef BUS_DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .m_grant   (m_grant),
        .m_din     (m_din),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .busy      (busy),
        .done      (done)
    );

    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Pulses start; returns at the falling edge of cycle 1 (first cycle after start).
    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes `budget` cycles starting now (c=1), recording the first done cycle.
    task automatic watch(input int budget, output int done_cyc, output int pulses,
                         output logic req_at_done, output int req_cycles);
        done_cyc = -1; pulses = 0; req_at_done = 1'bx; req_cycles = 0;
        for (int c = 1; c <= budget; c++) begin
            if (m_req) req_cycles++;
            if (done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    req_at_done = m_req;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({m_req, m_wr, m_addr, m_dout, busy, done} !== '0)
            $display("FAIL reset_outputs: got req=%b wr=%b addr=%h dout=%h busy=%b done=%b, want all 0",
                     m_req, m_wr, m_addr, m_dout, busy, done);
        else n_pass++;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_req, busy, done} !== 3'b000)
            $display("FAIL idle_after_reset: got req=%b busy=%b done=%b, want 000", m_req, busy, done);
        else n_pass++;
    endtask

    task automatic test_copy;
        int dc, p, rc, base;
        logic r;
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 64'hA0 + 64'(i));
        base = wr_log.size();
        do_start(16'h0010, 16'h0100, 8'd4);
        n_checks++;
        if ({m_req, m_wr, m_addr, busy} !== {1'b1, 1'b0, 16'h0000, 1'b1})
            $display("FAIL copy_cycle1_req: got req=%b wr=%b addr=%h busy=%b, want 1 0 0000 1",
                     m_req, m_wr, m_addr, busy);
        else n_pass++;
        watch(25, dc, p, r, rc);
        // REQ 1-2, then three cycles per word, DONE at 2+3*4+1.
        n_checks++;
        if (dc !== 15) $display("FAIL copy_done_cycle: got %0d, want 15", dc); else n_pass++;
        n_checks++;
        if (p !== 1) $display("FAIL copy_done_pulses: got %0d, want 1", p); else n_pass++;
        n_checks++;
        if (r !== 1'b0) $display("FAIL copy_req_at_done: got %b, want 0", r); else n_pass++;
        n_checks++;
        if (wr_log.size() - base !== 4) $display("FAIL copy_write_count: got %0d, want 4", wr_log.size() - base);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            a = 16'h0100 + 16'(i);
            n_checks++;
            if (mem[a] !== 64'hA0 + 64'(i) || wr_log[base + i] !== a)
                $display("FAIL copy_word%0d: got mem=%h at write addr %h, want %h at %h",
                         i, mem[a], wr_log[base + i], 64'hA0 + 64'(i), a);
            else n_pass++;
        end
    endtask

    task automatic test_zero_length;
        int dc, p, rc, base;
        logic r;
        base = wr_log.size();
        do_start(16'h0010, 16'h0100, 8'd0);
        watch(6, dc, p, r, rc);
        n_checks++;
        if (dc !== 1 || p !== 1) $display("FAIL zero_len_done: got cycle %0d pulses %0d, want cycle 1 pulses 1", dc, p);
        else n_pass++;
        n_checks++;
        if (rc !== 0) $display("FAIL zero_len_req: got %0d request cycles, want 0", rc); else n_pass++;
        n_checks++;
        if (wr_log.size() !== base) $display("FAIL zero_len_writes: got %0d writes, want 0", wr_log.size() - base);
        else n_pass++;
    endtask

    task automatic test_addr_wrap;
        int dc, p, rc, base;
        logic r;
        logic [63:0] exp_data [3];
        exp_data[0] = 64'h1111; exp_data[1] = 64'h2222; exp_data[2] = 64'h3333;
        preload(16'hFFFE, exp_data[0]);
        preload(16'hFFFF, exp_data[1]);
        preload(16'h0000, exp_data[2]);
        base = wr_log.size();
        do_start(16'hFFFE, 16'h0200, 8'd3);
        watch(20, dc, p, r, rc);
        n_checks++;
        if (dc !== 12 || p !== 1) $display("FAIL wrap_done: got cycle %0d pulses %0d, want 12 and 1", dc, p);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = 16'h0200 + 16'(i);
            n_checks++;
            if (mem[a] !== exp_data[i] || wr_log[base + i] !== a)
                $display("FAIL wrap_word%0d: got mem=%h at write addr %h, want %h at %h",
                         i, mem[a], wr_log[base + i], exp_data[i], a);
            else n_pass++;
        end
    endtask

    task automatic test_grant_delay;
        int dc, p, rc, base;
        logic r;
        preload(16'h0020, 64'hC0);
        preload(16'h0021, 64'hC1);
        base = wr_log.size();
        grant_block = 1'b1;
        do_start(16'h0020, 16'h0300, 8'd2);
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if ({m_req, m_wr, m_addr, busy} !== {1'b1, 1'b0, 16'h0000, 1'b1})
                $display("FAIL grant_wait_c%0d: got req=%b wr=%b addr=%h busy=%b, want 1 0 0000 1",
                         c, m_req, m_wr, m_addr, busy);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (wr_log.size() !== base) $display("FAIL grant_early_write: got %0d writes, want 0", wr_log.size() - base);
        else n_pass++;
        grant_block = 1'b0;
        // Granted REQ now, RD/RD_WAIT/WR twice, DONE on the 8th observed cycle.
        watch(20, dc, p, r, rc);
        n_checks++;
        if (dc !== 8 || p !== 1) $display("FAIL grant_done: got cycle %0d pulses %0d, want 8 and 1", dc, p);
        else n_pass++;
        n_checks++;
        if (mem[16'h0300] !== 64'hC0 || mem[16'h0301] !== 64'hC1)
            $display("FAIL grant_data: got %h %h, want c0 c1", mem[16'h0300], mem[16'h0301]);
        else n_pass++;
    endtask

    task automatic test_grant_drop_in_wr;
        int dc, p, rc, base;
        logic r;
        preload(16'h0030, 64'hD0);
        base = wr_log.size();
        do_start(16'h0030, 16'h0600, 8'd1);
        repeat (4) @(negedge clk);
        grant_block = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({m_req, m_wr, m_addr, m_dout, done} !== {1'b1, 1'b1, 16'h0600, 64'hD0, 1'b0} || wr_log.size() !== base)
                $display("FAIL wr_hold_c%0d: got req=%b wr=%b addr=%h dout=%h done=%b writes=%0d, want 1 1 0600 d0 0 0",
                         c, m_req, m_wr, m_addr, m_dout, done, wr_log.size() - base);
            else n_pass++;
        end
        grant_block = 1'b0;
        watch(10, dc, p, r, rc);
        n_checks++;
        if (dc !== 2 || mem[16'h0600] !== 64'hD0 || wr_log.size() - base !== 1)
            $display("FAIL wr_hold_resume: got done cycle %0d data %h writes %0d, want 2 d0 1",
                     dc, mem[16'h0600], wr_log.size() - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid_transfer;
        int dc, p, rc, base;
        logic r;
        for (int i = 0; i < 5; i++) preload(16'h0040 + 16'(i), 64'hB0 + 64'(i));
        base = wr_log.size();
        do_start(16'h0040, 16'h0400, 8'd5);
        repeat (7) @(negedge clk);
        n_checks++;
        if ({m_wr, m_addr} !== {1'b1, 16'h0401})
            $display("FAIL abort_in_wr2: got wr=%b addr=%h, want 1 0401", m_wr, m_addr);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_req, m_wr, m_addr, m_dout, busy, done} !== '0)
            $display("FAIL abort_outputs: got req=%b wr=%b addr=%h dout=%h busy=%b done=%b, want all 0",
                     m_req, m_wr, m_addr, m_dout, busy, done);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (wr_log.size() - base !== 1 || wr_log[base] !== 16'h0400)
            $display("FAIL abort_writes: got %0d writes first at %h, want 1 at 0400",
                     wr_log.size() - base, wr_log[base]);
        else n_pass++;
        do_start(16'h0040, 16'h0500, 8'd2);
        watch(20, dc, p, r, rc);
        n_checks++;
        if (dc !== 9 || mem[16'h0500] !== 64'hB0 || mem[16'h0501] !== 64'hB1)
            $display("FAIL abort_restart: got done cycle %0d data %h %h, want 9 b0 b1",
                     dc, mem[16'h0500], mem[16'h0501]);
        else n_pass++;
    endtask

`ifdef BUS_DMA_FILL_EN
    task automatic test_fill;
        int dc, p, rc, base;
        logic r;
        base = wr_log.size();
        fill = 1'b1; fill_data = 64'hDEAD_BEEF_0000_0001;
        do_start(16'h0000, 16'h7000, 8'd3);
        fill = 1'b0; fill_data = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m_req, m_wr, m_addr, m_dout} !== {1'b1, 1'b1, 16'h7000 + 16'(i), 64'hDEAD_BEEF_0000_0001})
                $display("FAIL fill_wr%0d: got req=%b wr=%b addr=%h dout=%h, want 1 1 %h deadbeef00000001",
                         i, m_req, m_wr, m_addr, m_dout, 16'h7000 + 16'(i));
            else n_pass++;
        end
        @(negedge clk);
        watch(4, dc, p, r, rc);
        n_checks++;
        if (dc !== 1 || wr_log.size() - base !== 3 || mem[16'h7002] !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL fill_done: got done cycle %0d writes %0d last %h, want 1 3 deadbeef00000001",
                     dc, wr_log.size() - base, mem[16'h7002]);
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_copy();
        test_zero_length();
        test_addr_wrap();
        test_grant_delay();
        test_grant_drop_in_wr();
        test_reset_mid_transfer();
`ifdef BUS_DMA_FILL_EN
        test_fill();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
